// File: rtl/fpmul_bus_master_if.sv
// Bundle of the command, response and peripheral-bus signals of fpmul_bus_master.
//   cmd_*     : operand-pair request (valid/ready), driven by the requester.
//   rsp_*     : product, flags and abort status (valid/ready), returned to the requester.
//   op_count  : completed-operation counter, wraps.
//   bus_*     : 2-bit-address register bus towards the FP multiplier peripheral.
// modport master : the bus initiator's view.
// modport slave  : the requester/peripheral side view.
interface fpmul_bus_master_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_p;
  logic [5:0]       rsp_flags;
  logic             rsp_timeout;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       bus_a;
  logic             bus_we;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, rsp_ready, bus_rdata,
    output cmd_ready, rsp_valid, rsp_p, rsp_flags, rsp_timeout, op_count,
    output bus_a, bus_we, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, rsp_ready, bus_rdata,
    input  cmd_ready, rsp_valid, rsp_p, rsp_flags, rsp_timeout, op_count,
    input  bus_a, bus_we, bus_wdata
  );
endinterface

// File: rtl/fpmul_bus_master.sv
// Bus initiator for the memory-mapped FP multiplier peripheral.
// Takes an operand pair on the command port, runs the register sequence
// (write OpA, write OpB, write Start, poll status, read product, clear Start)
// and returns product and flags on the response port.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-low reset
//   mst  : fpmul_bus_master_if.master (cmd_*, rsp_*, op_count, bus_*)
// Optional feature: define FPMUL_MST_TIMEOUT_EN to abort polling after TIMEOUT
// POLL cycles without Done (response then carries rsp_timeout=1, rsp_p=0).
// All outputs are flops loaded from the next state, so nothing combinational
// reaches bus_a/bus_we/bus_wdata from any input.
module fpmul_bus_master #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input logic                 clk,
  input logic                 rst,
  fpmul_bus_master_if.master  mst
);

  typedef enum logic [3:0] {
    StIdle, StWrA, StWrB, StWrGo, StGap, StPoll, StRdP, StWrClr, StResp
  } state_e;

  localparam logic [31:0] StartWord = 32'h0001_0000;

  state_e           state_q, state_d;
  logic [31:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]       bus_a_q, bus_a_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_p_q, rsp_p_d;
  logic [5:0]       rsp_flags_q, rsp_flags_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

`ifdef FPMUL_MST_TIMEOUT_EN
  localparam int unsigned PollW = $clog2(TIMEOUT + 1);
  logic             rsp_timeout_q, rsp_timeout_d;
  logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
`else
  localparam int unsigned UnusedTimeout = TIMEOUT;
`endif

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_p_d     = rsp_p_q;
    rsp_flags_d = rsp_flags_q;
    op_count_d  = op_count_q;
`ifdef FPMUL_MST_TIMEOUT_EN
    rsp_timeout_d = rsp_timeout_q;
    poll_cnt_d    = poll_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (mst.cmd_valid && cmd_ready_q) begin
          op_a_d  = mst.cmd_a;
          op_b_d  = mst.cmd_b;
          state_d = StWrA;
        end
      end
      StWrA:  state_d = StWrB;
      StWrB:  state_d = StWrGo;
      StWrGo: begin
        state_d = StGap;
`ifdef FPMUL_MST_TIMEOUT_EN
        poll_cnt_d = '0;
`endif
      end
      StGap:  state_d = StPoll;
      StPoll: begin
        if (mst.bus_rdata[0]) begin
          rsp_flags_d = mst.bus_rdata[13:8];
          state_d     = StRdP;
`ifdef FPMUL_MST_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
        end else if (poll_cnt_q == PollW'(TIMEOUT - 1)) begin
          // Last allowed poll without Done: abort and skip the product read.
          rsp_p_d       = '0;
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = StWrClr;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
`endif
        end
      end
      StRdP: begin
        rsp_p_d = mst.bus_rdata;
        state_d = StWrClr;
      end
      StWrClr: state_d = StResp;
      StResp: begin
        if (rsp_valid_q && mst.rsp_ready) begin
          op_count_d = op_count_q + 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered output decode of the state being entered.
  always_comb begin
    bus_a_d     = 2'd3;
    bus_we_d    = 1'b0;
    bus_wdata_d = '0;
    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    unique case (state_d)
      StIdle:  cmd_ready_d = 1'b1;
      StWrA: begin
        bus_a_d     = 2'd0;
        bus_we_d    = 1'b1;
        bus_wdata_d = op_a_d;
      end
      StWrB: begin
        bus_a_d     = 2'd1;
        bus_we_d    = 1'b1;
        bus_wdata_d = op_b_d;
      end
      StWrGo: begin
        bus_a_d     = 2'd2;
        bus_we_d    = 1'b1;
        bus_wdata_d = StartWord;
      end
      StRdP:   bus_a_d = 2'd2;
      StWrClr: begin
        bus_a_d  = 2'd2;
        bus_we_d = 1'b1;
      end
      StResp:  rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      op_a_q      <= '0;
      op_b_q      <= '0;
      bus_a_q     <= '0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_p_q     <= '0;
      rsp_flags_q <= '0;
      op_count_q  <= '0;
`ifdef FPMUL_MST_TIMEOUT_EN
      rsp_timeout_q <= 1'b0;
      poll_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      bus_a_q     <= bus_a_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_p_q     <= rsp_p_d;
      rsp_flags_q <= rsp_flags_d;
      op_count_q  <= op_count_d;
`ifdef FPMUL_MST_TIMEOUT_EN
      rsp_timeout_q <= rsp_timeout_d;
      poll_cnt_q    <= poll_cnt_d;
`endif
    end
  end

  assign mst.cmd_ready = cmd_ready_q;
  assign mst.rsp_valid = rsp_valid_q;
  assign mst.rsp_p     = rsp_p_q;
  assign mst.rsp_flags = rsp_flags_q;
  assign mst.op_count  = op_count_q;
  assign mst.bus_a     = bus_a_q;
  assign mst.bus_we    = bus_we_q;
  assign mst.bus_wdata = bus_wdata_q;
`ifdef FPMUL_MST_TIMEOUT_EN
  assign mst.rsp_timeout = rsp_timeout_q;
`else
  assign mst.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fpmul_bus_master.sv
// Self-checking bench for fpmul_bus_master: a peripheral stub with a
// programmable Done delay, a transaction-level model of the expected bus
// writes, responses, latency and op_count, and directed plus random traffic.
module tb_fpmul_bus_master;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpmul_bus_master_if #(.CNT_W(16)) ifc ();

  fpmul_bus_master #(.TIMEOUT(TO), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .mst (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Simple normal-range FP multiply (truncating) used as the peripheral's product.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    int e;
    if (a[30:0] == 0 || b[30:0] == 0) return {a[31] ^ b[31], 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24];
      e++;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [5:0] fflags(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == 0 || b[30:0] == 0) ? 6'b000001 : 6'b000000;
  endfunction

  // ---------------- peripheral stub ----------------
  logic [31:0] s_opa = 0, s_opb = 0, s_prod = 0;
  logic [5:0]  s_flags = 0;
  logic        s_start = 0, s_done = 0;
  int          s_cnt = 0;
  int          done_delay = 1;

  always @(posedge clk) begin
    if (ifc.bus_we && ifc.bus_a == 2'd0) s_opa <= ifc.bus_wdata;
    if (ifc.bus_we && ifc.bus_a == 2'd1) s_opb <= ifc.bus_wdata;
    if (ifc.bus_we && ifc.bus_a == 2'd2) s_start <= ifc.bus_wdata[16];
    if (ifc.bus_we && ifc.bus_a == 2'd2 && ifc.bus_wdata[16]) begin
      s_done  <= 1'b0;
      s_cnt   <= done_delay;
      s_prod  <= fmul(s_opa, s_opb);
      s_flags <= fflags(s_opa, s_opb);
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1) s_done <= 1'b1;
    end
  end

  always_comb begin
    case (ifc.bus_a)
      2'd0:    ifc.bus_rdata = s_opa;
      2'd1:    ifc.bus_rdata = s_opb;
      2'd2:    ifc.bus_rdata = s_prod;
      default: ifc.bus_rdata = {15'b0, s_start, 2'b0, s_flags, 7'b0, s_done};
    endcase
  end

  // ---------------- reference model + compare ----------------
  typedef struct { logic [31:0] p; logic [5:0] f; logic t; int lat; } rsp_t;
  typedef struct { logic [1:0] a; logic [31:0] d; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t er;
  wr_t  ew;
  int   cyc = 0, accept_cyc = 0, last_lat = 0, n_rsp = 0, exp_count = 0;
  int   first_seen, n_polls;
  bit   busy = 0, prev_valid = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      rsp_q.delete();
      wr_q.delete();
      busy = 0;
      prev_valid = 0;
      exp_count = 0;
    end else begin
      chk("cmd_ready", ifc.cmd_ready, !busy);
      if (!busy) begin
        chk("idle_bus_a", ifc.bus_a, 2'd3);
        chk("idle_bus_we", ifc.bus_we, 1'b0);
      end
      if (ifc.bus_we) begin
        if (wr_q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else begin
          ew = wr_q.pop_front();
          chk("wr_addr", ifc.bus_a, ew.a);
          chk("wr_data", ifc.bus_wdata, ew.d);
        end
      end
      chk("op_count", ifc.op_count, exp_count[15:0]);
      if (ifc.rsp_valid) begin
        chk("resp_bus_we", ifc.bus_we, 1'b0);
        if (rsp_q.size() == 0) chk("unexpected_rsp", 1'b1, 1'b0);
        else begin
          chk("rsp_p", ifc.rsp_p, rsp_q[0].p);
          chk("rsp_flags", ifc.rsp_flags, rsp_q[0].f);
          chk("rsp_timeout", ifc.rsp_timeout, rsp_q[0].t);
          if (!prev_valid) begin
            last_lat = cyc - accept_cyc;
            chk("latency", last_lat, rsp_q[0].lat);
            chk("writes_done", wr_q.size(), 0);
          end
        end
      end
      prev_valid = ifc.rsp_valid;
      if (ifc.cmd_valid && ifc.cmd_ready) begin
        // Done becomes visible in cycle done_delay+4 after accept; polling starts in cycle 5.
        first_seen = (done_delay + 4 > 5) ? done_delay + 4 : 5;
        n_polls = first_seen - 4;
        er.p = fmul(ifc.cmd_a, ifc.cmd_b);
        er.f = fflags(ifc.cmd_a, ifc.cmd_b);
        er.t = 1'b0;
        er.lat = n_polls + 7;
`ifdef FPMUL_MST_TIMEOUT_EN
        if (n_polls > TO) begin
          er.p = 0;
          er.f = 0;
          er.t = 1'b1;
          er.lat = TO + 6;
        end
`endif
        rsp_q.push_back(er);
        wr_q.push_back('{a: 2'd0, d: ifc.cmd_a});
        wr_q.push_back('{a: 2'd1, d: ifc.cmd_b});
        wr_q.push_back('{a: 2'd2, d: 32'h0001_0000});
        wr_q.push_back('{a: 2'd2, d: 32'h0000_0000});
        accept_cyc = cyc;
        busy = 1;
      end
      if (ifc.rsp_valid && ifc.rsp_ready) begin
        if (rsp_q.size() > 0) void'(rsp_q.pop_front());
        exp_count++;
        n_rsp++;
        busy = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input int d);
    bit ok = 0;
    @(posedge clk);
    #1;
    done_delay = d;
    ifc.cmd_a = a;
    ifc.cmd_b = b;
    ifc.cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifc.cmd_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_a = $urandom;
    ifc.cmd_b = $urandom;
    if (!ok) chk("cmd_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic get_rsp(input int hold, output logic [31:0] p, output logic [5:0] f,
                         output logic t);
    bit ok = 0;
    p = 0;
    f = 0;
    t = 0;
    if (hold == 0) ifc.rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ifc.rsp_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      ifc.rsp_ready = 1'b0;
      chk("rsp_wait_timeout", 1'b0, 1'b1);
    end else begin
      p = ifc.rsp_p;
      f = ifc.rsp_flags;
      t = ifc.rsp_timeout;
      repeat (hold) @(posedge clk);
      #1 ifc.rsp_ready = 1'b1;
      @(posedge clk);
      #1 ifc.rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p, a, b;
    logic [5:0]  f;
    logic        t;
    int          base;
    bit          ok;
    ifc.cmd_valid = 0;
    ifc.cmd_a = 0;
    ifc.cmd_b = 0;
    ifc.rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", ifc.cmd_ready, 1'b0);
    chk("rst_bus_a", ifc.bus_a, 2'd0);
    chk("rst_bus_we", ifc.bus_we, 1'b0);
    chk("rst_bus_wdata", ifc.bus_wdata, 32'h0);
    chk("rst_rsp_valid", ifc.rsp_valid, 1'b0);
    chk("rst_rsp_p", ifc.rsp_p, 32'h0);
    chk("rst_rsp_flags", ifc.rsp_flags, 6'h0);
    chk("rst_rsp_timeout", ifc.rsp_timeout, 1'b0);
    chk("rst_op_count", ifc.op_count, 16'h0);
    #1 rst = 1'b1;

    // 2.0 x 3.0, Done four cycles after Start
    send(32'h4000_0000, 32'h4040_0000, 4);
    get_rsp(0, p, f, t);
    chk("t1_p", p, 32'h40C0_0000);
    chk("t1_flags", f, 6'h00);
    @(negedge clk);
    chk("t1_op_count", ifc.op_count, 16'd1);

    // zero operand, Done on first poll -> minimum latency
    send(32'h0000_0000, 32'h3F80_0000, 1);
    get_rsp(0, p, f, t);
    chk("t2_p", p, 32'h0);
    chk("t2_flags", f, 6'b000001);
    chk("t2_latency", last_lat, 8);

    // response back-pressure for five cycles
    send(32'h3FC0_0000, 32'h4000_0000, 2);
    get_rsp(5, p, f, t);
    chk("t3_p", p, 32'h4040_0000);

    // reset in the third POLL cycle
    send(32'h4000_0000, 32'h4000_0000, 20);
    repeat (7) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t4_bus_we", ifc.bus_we, 1'b0);
    chk("t4_bus_a", ifc.bus_a, 2'd0);
    chk("t4_rsp_valid", ifc.rsp_valid, 1'b0);
    chk("t4_cmd_ready", ifc.cmd_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    send(32'h4040_0000, 32'h4040_0000, 3);
    get_rsp(1, p, f, t);
    chk("t4_p", p, 32'h4110_0000);
    @(negedge clk);
    chk("t4_op_count", ifc.op_count, 16'd1);

`ifdef FPMUL_MST_TIMEOUT_EN
    send(32'h4000_0000, 32'h4040_0000, 1000);
    get_rsp(0, p, f, t);
    chk("t5_timeout", t, 1'b1);
    chk("t5_p", p, 32'h0);
    chk("t5_flags", f, 6'h0);
    chk("t5_latency", last_lat, TO + 6);
`endif

    // random traffic
    for (int i = 0; i < 20; i++) begin
      a = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(110, 145)), 23'($urandom)};
      if ($urandom_range(0, 7) == 0) a = 0;
      send(a, b, $urandom_range(1, 8));
      get_rsp($urandom_range(0, 3), p, f, t);
    end

    // back-to-back with cmd_valid held and rsp_ready high
    do_reset();
    base = n_rsp;
    @(posedge clk);
    #1;
    done_delay = 2;
    ifc.rsp_ready = 1'b1;
    ifc.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.cmd_a = {2'b01, 6'($urandom), 24'($urandom)};
      ifc.cmd_b = {2'b00, 6'h3F, 24'($urandom)};
      ok = 0;
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (ifc.cmd_ready) begin
          ok = 1;
          break;
        end
      end
      if (!ok) chk("t6_accept_timeout", 1'b0, 1'b1);
      @(posedge clk);
      #1;
    end
    ifc.cmd_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (n_rsp == base + 3) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("t6_rsp_timeout", 1'b0, 1'b1);
    @(negedge clk);
    chk("t6_op_count", ifc.op_count, 16'd3);
    ifc.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpmul_bus_master.md
Name: fpmul_bus_master

Overview:
- Bus initiator that drives the memory-mapped FP multiplier peripheral through its 2-bit-address register interface.
- Accepts an operand pair on a valid/ready command port and runs the full register sequence: write OpA, write OpB, write Start, poll status, read product, clear Start.
- Returns product and flags on a valid/ready response port.
- Sits between a processor-side or test-side requester and the multiplier peripheral.

Parameters:
- TIMEOUT, 1024, maximum POLL cycles before abort (used only with the optional feature).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_a  in  32  operand A, IEEE-754 single.
- cmd_b  in  32  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_p  out  32  product.
- rsp_flags  out  6  {OF,UF,NANF,INFF,DNF,ZF}.
- rsp_timeout  out  1  operation aborted.
- op_count  out  CNT_W  completed operations, wraps.
- bus_a  out  2  peripheral address.
- bus_we  out  1  peripheral write enable.
- bus_wdata  out  32  peripheral write data.
- bus_rdata  in  32  peripheral read data; combinational, valid in the same cycle as bus_a.

Behaviour:
- Peripheral map:
  - 0 = OpA (R/W).
  - 1 = OpB (R/W).
  - 2 = write bit16 as Start; read returns the product.
  - 3 = status: bit0 Done, bits13:8 {OF,UF,NANF,INFF,DNF,ZF}, bit16 Start.
- Bus outputs are decoded from the state and operand registers only; there is no combinational path from any input to bus_a, bus_we or bus_wdata.
- bus_we is high for exactly one cycle per write.
- States and transitions:
  - IDLE: cmd_ready=1, bus_we=0, bus_a=3. On cmd_valid&cmd_ready, latch cmd_a/cmd_b and go to WR_A.
  - WR_A: a=0, we=1, wdata=opA. Go to WR_B.
  - WR_B: a=1, we=1, wdata=opB. Go to WR_GO.
  - WR_GO: a=2, we=1, wdata=32'h0001_0000. Go to GAP.
  - GAP: a=3, we=0, one dead cycle so that the peripheral's Done clear and start pulse settle. Go to POLL.
  - POLL: a=3, we=0. If bus_rdata[0]=1, capture rsp_flags<=bus_rdata[13:8] and go to RD_P; otherwise stay in POLL.
  - RD_P: a=2, we=0, capture rsp_p<=bus_rdata. Go to WR_CLR.
  - WR_CLR: a=2, we=1, wdata=0 (deasserts Start). Go to RESP.
  - RESP: rsp_valid=1. Hold rsp_p, rsp_flags and rsp_timeout stable until rsp_valid&rsp_ready. On that handshake, increment op_count (wraps modulo 2^CNT_W) and go to IDLE.
- cmd_ready=0 in every state except IDLE; a cmd_valid outside IDLE is ignored, not lost.
- Latency: with N POLL cycles, rsp_valid rises in cycle N+7 after the accept cycle (minimum 8 cycles, with Done seen on the first poll).
- Response registers are not modified outside POLL and RD_P.
- Reset asserted, any state:
  - state=IDLE, bus_a=0, bus_we=0, bus_wdata=0 immediately (asynchronously).
  - cmd_ready=0 while reset is held.
  - rsp_valid=0, rsp_p=0, rsp_flags=0, rsp_timeout=0, op_count=0, poll counter=0.
- After reset deasserts, the first edge is in IDLE and cmd_ready=1.
- An interrupted operation is discarded; the peripheral may retain Start=1, and the next WR_GO/WR_CLR sequence recovers it.
- Simultaneous rsp handshake and cmd_valid: no same-cycle accept; the command is accepted in the following IDLE cycle.

Optional Feature:
- Macro: FPMUL_MST_TIMEOUT_EN.
- Defined:
  - A poll counter clears on entry to GAP and increments each POLL cycle.
  - When the counter reaches TIMEOUT with Done still 0, go to WR_CLR with rsp_p=0, rsp_flags=0, rsp_timeout=1.
  - RD_P is skipped.
  - op_count still increments on the handshake.
- Undefined:
  - POLL waits indefinitely.
  - rsp_timeout is tied 0.
  - No counter is present.

Test Plan:
- 1. cmd_a=32'h4000_0000, cmd_b=32'h4040_0000 (2.0×3.0), peripheral model with Done after 4 cycles -> bus writes 0:40000000, 1:40400000, 2:00010000; then polls; then RD_P and WR_CLR 2:00000000; response is rsp_p=32'h40C0_0000, rsp_flags=0, op_count=1.
- 2. cmd_a=0, cmd_b=32'h3F80_0000 -> rsp_p=0, rsp_flags=6'b000001; Done on first poll gives rsp_valid exactly 8 cycles after accept.
- 3. rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_p and rsp_flags stable, cmd_ready=0, bus_we=0 throughout; handshake on cycle 6, then IDLE.
- 4. rst low during the third POLL cycle -> bus_we=0, bus_a=0 and rsp_valid=0 before the next edge; after release, cmd_ready=1; a new command completes correctly.
- 5. FPMUL_MST_TIMEOUT_EN, TIMEOUT=16, stub never sets Done -> exactly 16 POLL cycles, then WR_CLR, then rsp_timeout=1 with rsp_p=0.
- 6. 3 back-to-back commands with cmd_valid held high and rsp_ready=1 -> 3 ordered correct responses, op_count=3, no command accepted outside IDLE.
